// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced MODE/INC buttons walk RUN -> SET_H -> SET_M -> COMMIT.
// Latency: raw button edge to acted press is 2 + DEBOUNCE_CYCLES clocks; all outputs registered.
// Backpressure: none; presses that arrive where they have no meaning are dropped.

// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
// Latency: press asserts in the cycle before the filtered level rises (edge t+2+DEBOUNCE_CYCLES).
// Backpressure: none; the press pulse is one cycle wide and never held.
module clock_set_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             filt;
    logic             armed;
    logic [1:0]       primed;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw level, then let the filtered level follow only after a
    // full run of stable differing samples. A button held through reset is not a
    // press: the edge detector arms only once the synced level has been seen low
    // after the synchronizer has refilled with real samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            filt    <= 1'b0;
            armed   <= 1'b0;
            primed  <= 2'b00;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            primed  <= {primed[0], 1'b1};
            if (primed[1] && !sync_q2) begin
                armed <= 1'b1;
            end
            if (sync_q2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync_q2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pulse in the cycle whose edge flips the filtered level from 0 to 1.
    assign press = armed && sync_q2 && !filt && (cnt == CNT_LAST);

endmodule

// Top: sequences the time-set modes, edits shadow hours/minutes, issues the load pulse.
// Latency: a press is acted on at the same edge the debounced level rises; outputs one register.
// Backpressure: none; COMMIT is a single cycle and the counter must take the load.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 25_000_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic       blank_hours,
    output logic       blank_minutes,
    output logic [1:0] mode
);
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_H  = 2'd1,
        ST_SET_M  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 mode_press;
    logic                 inc_press;
    logic                 inc_taken;
    logic                 in_set;
    logic                 entering_set;
    logic                 idle_expired;
    logic [4:0]           hours_next;
    logic [5:0]           minutes_next;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [BLINK_W-1:0]   blink_cnt_next;
    logic                 phase;
    logic                 phase_next;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [IDLE_W-1:0]    idle_next;

    clock_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    clock_set_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .press (inc_press)
    );

    assign idle_expired = (idle_cnt == IDLE_LAST);

    // Next state and shadow time values; MODE outranks INC, and a press outranks timeout.
    always_comb begin
        state_next   = state;
        hours_next   = load_hours;
        minutes_next = load_minutes;
        inc_taken    = 1'b0;
        case (state)
            ST_RUN: begin
                if (mode_press) begin
                    hours_next   = cur_hours;
                    minutes_next = cur_minutes;
                    state_next   = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (mode_press) begin
                    state_next = ST_SET_M;
                end else if (inc_press) begin
                    inc_taken  = 1'b1;
                    hours_next = (load_hours == 5'd23) ? 5'd0 : load_hours + 5'd1;
                end else if (idle_expired) begin
                    state_next = ST_RUN;
                end
            end
            ST_SET_M: begin
                if (mode_press) begin
                    state_next = ST_COMMIT;
                end else if (inc_press) begin
                    inc_taken    = 1'b1;
                    minutes_next = (load_minutes == 6'd59) ? 6'd0 : load_minutes + 6'd1;
                end else if (idle_expired) begin
                    state_next = ST_RUN;
                end
            end
            ST_COMMIT: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Blink phase and idle timer; both restart whenever the user touches the field.
    always_comb begin
        in_set         = (state == ST_SET_H) || (state == ST_SET_M);
        entering_set   = (state_next != state) &&
                         ((state_next == ST_SET_H) || (state_next == ST_SET_M));
        blink_cnt_next = blink_cnt;
        phase_next     = phase;
        idle_next      = '0;
        if (entering_set || inc_taken) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (in_set) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                phase_next     = ~phase;
            end else begin
                blink_cnt_next = blink_cnt + BLINK_W'(1);
            end
        end
        if (in_set && (state_next == state) && !mode_press && !inc_press) begin
            idle_next = idle_cnt + IDLE_W'(1);
        end
    end

    // State register, counters, and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_RUN;
            blink_cnt     <= '0;
            phase         <= 1'b0;
            idle_cnt      <= '0;
            mode          <= 2'd0;
            run_en        <= 1'b1;
            load          <= 1'b0;
            load_hours    <= 5'd0;
            load_minutes  <= 6'd0;
            blank_hours   <= 1'b0;
            blank_minutes <= 1'b0;
        end else begin
            state         <= state_next;
            blink_cnt     <= blink_cnt_next;
            phase         <= phase_next;
            idle_cnt      <= idle_next;
            mode          <= state_next;
            run_en        <= (state_next == ST_RUN);
            load          <= (state_next == ST_COMMIT);
            load_hours    <= hours_next;
            load_minutes  <= minutes_next;
            blank_hours   <= (state_next == ST_SET_H) && phase_next;
            blank_minutes <= (state_next == ST_SET_M) && phase_next;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/blink/timeout parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Expected values are hand-derived: a clean press is acted on 6 edges after the raw rise.
module tb_clock_set_ctrl;
    localparam int DEB = 4;
    localparam int BH  = 8;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       run_en;
    logic       load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic       blank_hours;
    logic       blank_minutes;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    logic load_seen;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_HALF      (BH),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .cur_hours     (cur_hours),
        .cur_minutes   (cur_minutes),
        .run_en        (run_en),
        .load          (load),
        .load_hours    (load_hours),
        .load_minutes  (load_minutes),
        .blank_hours   (blank_hours),
        .blank_minutes (blank_minutes),
        .mode          (mode)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press: raw high for 6 edges, the press lands on the 6th; buttons dropped on return.
    task automatic do_press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        repeat (6) tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    initial begin
        reset       = 1'b0;
        btn_mode    = 1'b1;
        btn_inc     = 1'b1;
        cur_hours   = 5'd22;
        cur_minutes = 6'd58;

        // 1. Reset with both buttons held
        repeat (3) tick();
        check("rst_mode", mode, 0);
        check("rst_run_en", run_en, 1);
        check("rst_load", load, 0);
        check("rst_blank_h", blank_hours, 0);
        check("rst_blank_m", blank_minutes, 0);
        check("rst_load_h", load_hours, 0);
        check("rst_load_m", load_minutes, 0);
        reset = 1'b1;
        repeat (12) tick();
        check("held_thru_rst_mode", mode, 0);
        check("held_thru_rst_run_en", run_en, 1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        settle();
        check("post_rst_mode", mode, 0);

        // 3. Full set from 22:58, with the debounce checks while in SET_H
        do_press(1'b1, 1'b0);
        check("enter_h_mode", mode, 1);
        check("enter_h_hours", load_hours, 22);
        check("enter_h_minutes", load_minutes, 58);
        check("enter_h_run_en", run_en, 0);
        check("enter_h_blank", blank_hours, 0);
        settle();

        // 2. Debounce: 3-cycle glitch ignored, 12-cycle hold gives one increment at edge 6
        btn_inc = 1'b1;
        repeat (3) tick();
        btn_inc = 1'b0;
        repeat (10) tick();
        check("glitch_hours", load_hours, 22);
        btn_inc = 1'b1;
        repeat (5) tick();
        check("hold_edge5_hours", load_hours, 22);
        tick();
        check("hold_edge6_hours", load_hours, 23);
        repeat (6) tick();
        btn_inc = 1'b0;
        settle();
        check("hold_once_hours", load_hours, 23);

        do_press(1'b0, 1'b1);
        check("inc_wrap_hours", load_hours, 0);
        settle();
        do_press(1'b1, 1'b0);
        check("enter_m_mode", mode, 2);
        check("enter_m_blank_h", blank_hours, 0);
        settle();
        do_press(1'b0, 1'b1);
        check("inc_min_59", load_minutes, 59);
        settle();
        do_press(1'b0, 1'b1);
        check("inc_min_wrap", load_minutes, 0);
        settle();
        do_press(1'b1, 1'b0);
        check("commit_load", load, 1);
        check("commit_mode", mode, 3);
        check("commit_run_en", run_en, 0);
        check("commit_hours", load_hours, 0);
        check("commit_minutes", load_minutes, 0);
        tick();
        check("after_commit_load", load, 0);
        check("after_commit_mode", mode, 0);
        check("after_commit_run_en", run_en, 1);
        settle();

        // 5. Blink in SET_H: 8 visible, 8 blank; INC inside a blank half restarts visible
        do_press(1'b1, 1'b0);
        check("blink_entry_mode", mode, 1);
        check("blink_entry_hours", load_hours, 22);
        check("blink_entry_bh", blank_hours, 0);
        for (int k = 1; k <= 19; k++) begin
            tick();
            check("blink_bh", blank_hours, (k / 8) % 2);
            check("blink_bm", blank_minutes, 0);
        end
        do_press(1'b0, 1'b1);
        check("blink_inc_hours", load_hours, 23);
        check("blink_inc_bh", blank_hours, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("blink_after_inc_bh", blank_hours, (k >= 8) ? 1 : 0);
        end

        // 6a. MODE and INC pressed together in SET_H
        do_press(1'b1, 1'b1);
        check("both_mode", mode, 2);
        check("both_hours", load_hours, 23);
        check("both_minutes", load_minutes, 58);
        check("both_blank_h", blank_hours, 0);
        settle();

        // 6b. Reset while in SET_M
        check("pre_rst_mode", mode, 2);
        reset = 1'b0;
        tick();
        check("midrst_mode", mode, 0);
        check("midrst_run_en", run_en, 1);
        check("midrst_load", load, 0);
        check("midrst_hours", load_hours, 0);
        tick();
        check("midrst_load2", load, 0);
        reset = 1'b1;
        settle();
        check("midrst_after_mode", mode, 0);
        check("midrst_after_load", load, 0);

        // 4. Timeout from SET_M after 100 idle cycles
        do_press(1'b1, 1'b0);
        check("to_enter_h", mode, 1);
        settle();
        do_press(1'b1, 1'b0);
        check("to_enter_m", mode, 2);
        load_seen = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (load) load_seen = 1'b1;
            if (k == TO - 1) check("to_before_mode", mode, 2);
        end
        check("to_mode", mode, 0);
        check("to_run_en", run_en, 1);
        check("to_no_load", load_seen, 0);
        check("to_hours_held", load_hours, 22);
        check("to_minutes_held", load_minutes, 58);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
